// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back L1 data cache.
// Holds the default geometry, the derived address-field widths, the
// controller state encoding and a helper that rebuilds a line-aligned
// byte address from a tag and an index.
package dcache_pkg;

    localparam int DC_NUM_LINES = 16;
    localparam int DC_LINE_W    = 256;
    localparam int DC_ADDR_W    = 32;

    localparam int IDX_W  = $clog2(DC_NUM_LINES);
    localparam int OFF_W  = $clog2(DC_LINE_W / 8);
    localparam int TAG_W  = DC_ADDR_W - IDX_W - OFF_W;
    localparam int WSEL_W = $clog2(DC_LINE_W / 32);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_ALLOCATE  = 2'd2,
        ST_RESUME    = 2'd3
    } state_t;

    // Line-aligned byte address {tag, index, zero offset}.
    function automatic logic [DC_ADDR_W-1:0] line_addr(
        input logic [TAG_W-1:0] tag,
        input logic [IDX_W-1:0] idx
    );
        return {tag, idx, {OFF_W{1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_sram.sv
// Storage arrays of the data cache: per-line valid, dirty, tag and data.
// Ports:
//   clk, rst_n          clock; asynchronous active-low reset (clears valid/dirty)
//   line_idx            line addressed by both the read and the write port
//   rd_valid/rd_dirty   combinational status of the addressed line
//   rd_tag/rd_line      combinational tag and data of the addressed line
//   word_we/word_sel    store: replace one 32-bit word and mark the line dirty
//   word_data           store data
//   fill_we             refill: write whole line and tag, valid=1, dirty=0
//   fill_tag/fill_line  refill tag and data
// A refill takes priority over a word store to the same line.
module dcache_sram
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = DC_NUM_LINES,
    parameter int LINE_W    = DC_LINE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  line_idx,
    output logic              rd_valid,
    output logic              rd_dirty,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [LINE_W-1:0] rd_line,
    input  logic              word_we,
    input  logic [WSEL_W-1:0] word_sel,
    input  logic [31:0]       word_data,
    input  logic              fill_we,
    input  logic [TAG_W-1:0]  fill_tag,
    input  logic [LINE_W-1:0] fill_line
);

    logic [NUM_LINES-1:0] valid_r;
    logic [NUM_LINES-1:0] dirty_r;
    logic [TAG_W-1:0]     tag_mem_r  [NUM_LINES];
    logic [LINE_W-1:0]    data_mem_r [NUM_LINES];

    // Combinational read of the addressed line.
    always_comb begin
        rd_valid = valid_r[line_idx];
        rd_dirty = dirty_r[line_idx];
        rd_tag   = tag_mem_r[line_idx];
        rd_line  = data_mem_r[line_idx];
    end

    // Status bits: cleared by reset, set by refill (clean) or store (dirty).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= {NUM_LINES{1'b0}};
            dirty_r <= {NUM_LINES{1'b0}};
        end else if (fill_we) begin
            valid_r[line_idx] <= 1'b1;
            dirty_r[line_idx] <= 1'b0;
        end else if (word_we) begin
            dirty_r[line_idx] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; valid gates their use.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_mem_r[line_idx]  <= fill_tag;
            data_mem_r[line_idx] <= fill_line;
        end else if (word_we) begin
            data_mem_r[line_idx][{word_sel, 5'd0} +: 32] <= word_data;
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller (MEM stage).
// Hits complete in the access cycle; a miss stalls the pipeline, writes back a
// dirty victim if needed and refills the line over a req/ack memory handshake.
// Ports:
//   clk_i, rst_i             clock; asynchronous active-low reset
//   cpu_req_i/cpu_write_i    access request, 1 = store
//   cpu_addr_i/cpu_data_i    byte address (word aligned), store data
//   cpu_data_o               load data, 0 unless a load hits in IDLE
//   cpu_stall_o              freeze the pipeline
//   mem_req_o/mem_write_o    memory request, 1 = write-back, 0 = fetch
//   mem_addr_o/mem_data_o    line-aligned address, victim data
//   mem_data_i/mem_ack_i     fill data, one-cycle completion pulse
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = DC_NUM_LINES,
    parameter int LINE_W    = DC_LINE_W,
    parameter int ADDR_W    = DC_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_write_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [31:0]       cpu_data_i,
    output logic [31:0]       cpu_data_o,
    output logic              cpu_stall_o,
    output logic              mem_req_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i
);

    state_t              state_r;
    state_t              state_next_s;
    logic [ADDR_W-1:0]   miss_addr_r;
    logic                gap_r;

    logic [TAG_W-1:0]    cpu_tag_s;
    logic [IDX_W-1:0]    cpu_idx_s;
    logic [WSEL_W-1:0]   cpu_word_s;
    logic [TAG_W-1:0]    miss_tag_s;
    logic [IDX_W-1:0]    miss_idx_s;
    logic [IDX_W-1:0]    line_idx_s;

    logic                rd_valid_s;
    logic                rd_dirty_s;
    logic [TAG_W-1:0]    rd_tag_s;
    logic [LINE_W-1:0]   rd_line_s;
    logic                hit_s;
    logic [31:0]         load_word_s;

    logic                word_we_s;
    logic                fill_we_s;
    logic                miss_start_s;
    logic                wb_done_s;
    logic                addr_lsb_unused_s;

    assign cpu_tag_s         = cpu_addr_i[ADDR_W-1 -: TAG_W];
    assign cpu_idx_s         = cpu_addr_i[OFF_W +: IDX_W];
    assign cpu_word_s        = cpu_addr_i[2 +: WSEL_W];
    assign miss_tag_s        = miss_addr_r[ADDR_W-1 -: TAG_W];
    assign miss_idx_s        = miss_addr_r[OFF_W +: IDX_W];
    assign addr_lsb_unused_s = ^cpu_addr_i[1:0];

    // While a miss is in flight the arrays are addressed by the latched miss
    // line, so victim data and tag stay stable even if the CPU drops its request.
    always_comb begin
        if (state_r == ST_IDLE) begin
            line_idx_s = cpu_idx_s;
        end else begin
            line_idx_s = miss_idx_s;
        end
    end

    dcache_sram #(
        .NUM_LINES (NUM_LINES),
        .LINE_W    (LINE_W)
    ) u_sram (
        .clk       (clk_i),
        .rst_n     (rst_i),
        .line_idx  (line_idx_s),
        .rd_valid  (rd_valid_s),
        .rd_dirty  (rd_dirty_s),
        .rd_tag    (rd_tag_s),
        .rd_line   (rd_line_s),
        .word_we   (word_we_s),
        .word_sel  (cpu_word_s),
        .word_data (cpu_data_i),
        .fill_we   (fill_we_s),
        .fill_tag  (miss_tag_s),
        .fill_line (mem_data_i)
    );

    assign hit_s       = rd_valid_s & (rd_tag_s == cpu_tag_s);
    assign load_word_s = rd_line_s[{cpu_word_s, 5'd0} +: 32];

    // Stall is forced low while reset is held so the pipeline is released at once.
    assign cpu_stall_o = rst_i & ((state_r != ST_IDLE) | (cpu_req_i & ~hit_s));

    // Load data path: only a load hit in IDLE drives a non-zero value.
    always_comb begin
        if ((state_r == ST_IDLE) && cpu_req_i && !cpu_write_i && hit_s) begin
            cpu_data_o = load_word_s;
        end else begin
            cpu_data_o = 32'd0;
        end
    end

    // State, latched miss line and the one-cycle request gap after a write-back.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r     <= ST_IDLE;
            miss_addr_r <= {ADDR_W{1'b0}};
            gap_r       <= 1'b0;
        end else begin
            state_r <= state_next_s;
            gap_r   <= wb_done_s;
            if (miss_start_s) begin
                miss_addr_r <= line_addr(cpu_tag_s, cpu_idx_s);
            end
        end
    end

    // Next-state, memory handshake outputs and array write strobes.
    always_comb begin
        state_next_s = state_r;
        mem_req_o    = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = {ADDR_W{1'b0}};
        mem_data_o   = {LINE_W{1'b0}};
        word_we_s    = 1'b0;
        fill_we_s    = 1'b0;
        miss_start_s = 1'b0;
        wb_done_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cpu_req_i) begin
                    if (hit_s) begin
                        word_we_s = cpu_write_i;
                    end else begin
                        miss_start_s = 1'b1;
                        if (rd_valid_s && rd_dirty_s) begin
                            state_next_s = ST_WRITEBACK;
                        end else begin
                            state_next_s = ST_ALLOCATE;
                        end
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WRITEBACK: begin
                mem_req_o   = 1'b1;
                mem_write_o = 1'b1;
                mem_addr_o  = line_addr(rd_tag_s, miss_idx_s);
                mem_data_o  = rd_line_s;
                if (mem_ack_i) begin
                    wb_done_s    = 1'b1;
                    state_next_s = ST_ALLOCATE;
                end else begin
                    state_next_s = ST_WRITEBACK;
                end
            end
            ST_ALLOCATE: begin
                // First ALLOCATE cycle after a write-back keeps the request low.
                mem_req_o  = ~gap_r;
                mem_addr_o = miss_addr_r;
                if (mem_ack_i && !gap_r) begin
                    fill_we_s    = 1'b1;
                    state_next_s = ST_RESUME;
                end else begin
                    state_next_s = ST_ALLOCATE;
                end
            end
            ST_RESUME: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a small memory model and two
// scoreboards: expected memory transactions and expected load data.
module tb_dcache_controller;

    typedef struct packed {
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] data;
    } txn_t;

    logic         clk;
    logic         rst_i;
    logic         cpu_req_i;
    logic         cpu_write_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_data_i;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic         mem_req_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;

    int checks;
    int failures;
    int cyc;

    txn_t         exp_q[$];
    logic [31:0]  load_q[$];
    logic [255:0] mem_m [logic [31:0]];

    dcache_controller dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .cpu_req_i   (cpu_req_i),
        .cpu_write_i (cpu_write_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_data_i  (cpu_data_i),
        .cpu_data_o  (cpu_data_o),
        .cpu_stall_o (cpu_stall_o),
        .mem_req_o   (mem_req_o),
        .mem_write_o (mem_write_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .mem_data_i  (mem_data_i),
        .mem_ack_i   (mem_ack_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [255:0] read_mem(input logic [31:0] a);
        logic [255:0] l;
        if (mem_m.exists(a)) begin
            l = mem_m[a];
        end else begin
            l = {8{a}};
        end
        return l;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a, input int w);
        logic [255:0] l;
        l = read_mem(a);
        return l[w*32 +: 32];
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive an access just after a rising edge; returns at that cycle's falling edge.
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        @(posedge clk);
        #1;
        cpu_req_i   = 1'b1;
        cpu_write_i = wr;
        cpu_addr_i  = addr;
        cpu_data_i  = data;
        @(negedge clk);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        cpu_req_i   = 1'b0;
        cpu_write_i = 1'b0;
        @(negedge clk);
    endtask

    // Wait for a request, compare it to the next expected transaction every
    // cycle it is held, ack it in its delay-th cycle, then expect it to drop.
    task automatic serve(input int delay);
        txn_t e;
        int   n;
        n = 0;
        while (mem_req_o !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("mem_req_rise", {255'd0, mem_req_o}, 256'd1);
        check("txn_pending", 256'(exp_q.size() > 0), 256'd1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        for (int k = 1; k <= delay; k++) begin
            check("mem_req_hold", {255'd0, mem_req_o}, 256'd1);
            check("mem_write", {255'd0, mem_write_o}, {255'd0, e.wr});
            check("mem_addr", {224'd0, mem_addr_o}, {224'd0, e.addr});
            if (e.wr) begin
                check("mem_data", mem_data_o, e.data);
            end
            if (k < delay) begin
                @(negedge clk);
            end
        end
        mem_ack_i  = 1'b1;
        mem_data_i = e.wr ? 256'd0 : read_mem(e.addr);
        @(negedge clk);
        mem_ack_i  = 1'b0;
        mem_data_i = 256'd0;
        if (e.wr) begin
            mem_m[e.addr] = e.data;
        end
        check("mem_req_drop", {255'd0, mem_req_o}, 256'd0);
    endtask

    // Wait (bounded) for the stall to clear; loads pop and compare their data.
    task automatic complete(input string tag);
        int n;
        logic [31:0] exp_d;
        n = 0;
        while (cpu_stall_o !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_stall"}, {255'd0, cpu_stall_o}, 256'd0);
        if (!cpu_write_i) begin
            check({tag, "_load_pending"}, 256'(load_q.size() > 0), 256'd1);
            exp_d = (load_q.size() > 0) ? load_q.pop_front() : 32'd0;
            check({tag, "_data"}, {224'd0, cpu_data_o}, {224'd0, exp_d});
        end
    endtask

    initial begin
        logic [255:0] shadow;
        int           c0;
        int           n;

        checks = 0;   failures = 0;  cyc = 0;
        rst_i = 1'b0; cpu_req_i = 1'b0; cpu_write_i = 1'b0;
        cpu_addr_i = 32'd0; cpu_data_i = 32'd0;
        mem_data_i = 256'd0; mem_ack_i = 1'b0;

        mem_m[32'h40]  = {32'hA000_0007, 32'hA000_0006, 32'hA000_0005, 32'hA000_0004,
                          32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'h0000_0007};
        mem_m[32'h240] = {32'hB000_0007, 32'hB000_0006, 32'hB000_0005, 32'hB000_0004,
                          32'hB000_0003, 32'hB000_0002, 32'hB000_0001, 32'hB000_0000};

        // Reset state
        @(negedge clk);
        check("rst_stall", {255'd0, cpu_stall_o}, 256'd0);
        check("rst_req", {255'd0, mem_req_o}, 256'd0);
        check("rst_write", {255'd0, mem_write_o}, 256'd0);
        check("rst_addr", {224'd0, mem_addr_o}, 256'd0);
        check("rst_mdata", mem_data_o, 256'd0);
        check("rst_cdata", {224'd0, cpu_data_o}, 256'd0);
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);

        // Cold load: 12 stalled cycles with ack in the 10th request cycle
        shadow = read_mem(32'h40);
        exp_q.push_back('{1'b0, 32'h40, 256'd0});
        load_q.push_back(32'h0000_0007);
        issue(1'b0, 32'h40, 32'd0);
        c0 = cyc;
        check("cold_stall_now", {255'd0, cpu_stall_o}, 256'd1);
        serve(10);
        complete("cold");
        check("cold_stall_cycles", 256'(cyc - c0), 256'd12);

        // Hit path: load, store, load back
        load_q.push_back(mem_word(32'h40, 1));
        issue(1'b0, 32'h44, 32'd0);
        check("hit44_stall", {255'd0, cpu_stall_o}, 256'd0);
        complete("hit44");
        check("hit44_noreq", {255'd0, mem_req_o}, 256'd0);
        issue(1'b1, 32'h48, 32'hDEAD_BEEF);
        check("st48_stall", {255'd0, cpu_stall_o}, 256'd0);
        complete("st48");
        shadow[64 +: 32] = 32'hDEAD_BEEF;
        load_q.push_back(32'hDEAD_BEEF);
        issue(1'b0, 32'h48, 32'd0);
        check("ld48_stall", {255'd0, cpu_stall_o}, 256'd0);
        complete("ld48");
        check("ld48_noreq", {255'd0, mem_req_o}, 256'd0);

        // Dirty eviction with a long write-back handshake
        issue(1'b1, 32'h40, 32'h1234_5678);
        complete("st40");
        shadow[0 +: 32] = 32'h1234_5678;
        exp_q.push_back('{1'b1, 32'h40, shadow});
        exp_q.push_back('{1'b0, 32'h240, 256'd0});
        load_q.push_back(mem_word(32'h240, 0));
        issue(1'b0, 32'h240, 32'd0);
        check("evict_stall_now", {255'd0, cpu_stall_o}, 256'd1);
        serve(25);
        serve(4);
        complete("evict");

        // Refetch of the written-back line
        exp_q.push_back('{1'b0, 32'h40, 256'd0});
        load_q.push_back(32'h1234_5678);
        issue(1'b0, 32'h40, 32'd0);
        serve(3);
        complete("refetch");

        // Clean eviction: fetch only
        exp_q.push_back('{1'b0, 32'h240, 256'd0});
        load_q.push_back(mem_word(32'h240, 0));
        issue(1'b0, 32'h240, 32'd0);
        serve(2);
        complete("clean");
        check("clean_no_extra_txn", 256'(exp_q.size()), 256'd0);

        // No request: no stall, zero data; spurious ack ignored
        idle();
        check("noreq_stall", {255'd0, cpu_stall_o}, 256'd0);
        check("noreq_data", {224'd0, cpu_data_o}, 256'd0);
        mem_ack_i  = 1'b1;
        mem_data_i = {256{1'b1}};
        @(negedge clk);
        mem_ack_i  = 1'b0;
        mem_data_i = 256'd0;
        check("spurious_req", {255'd0, mem_req_o}, 256'd0);
        load_q.push_back(mem_word(32'h240, 1));
        issue(1'b0, 32'h244, 32'd0);
        check("spurious_hit_stall", {255'd0, cpu_stall_o}, 256'd0);
        complete("spurious_hit");

        // Reset during ALLOCATE
        idle();
        issue(1'b0, 32'h40, 32'd0);
        n = 0;
        while (mem_req_o !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("midmiss_req", {255'd0, mem_req_o}, 256'd1);
        rst_i = 1'b0;
        #1;
        check("midrst_req", {255'd0, mem_req_o}, 256'd0);
        check("midrst_stall", {255'd0, cpu_stall_o}, 256'd0);
        check("midrst_addr", {224'd0, mem_addr_o}, 256'd0);
        check("midrst_cdata", {224'd0, cpu_data_o}, 256'd0);
        cpu_req_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        mem_ack_i  = 1'b1;
        mem_data_i = {256{1'b1}};
        @(negedge clk);
        mem_ack_i  = 1'b0;
        mem_data_i = 256'd0;
        check("late_ack_req", {255'd0, mem_req_o}, 256'd0);
        check("late_ack_stall", {255'd0, cpu_stall_o}, 256'd0);
        exp_q.push_back('{1'b0, 32'h240, 256'd0});
        load_q.push_back(mem_word(32'h240, 1));
        issue(1'b0, 32'h244, 32'd0);
        check("post_rst_miss", {255'd0, cpu_stall_o}, 256'd1);
        serve(5);
        complete("post_rst");
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
